// File: rtl/mux2_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux2_arb_pkg
// Shared definitions for the two-requester round-robin packet arbiter:
//   - arb_state_e : arbiter FSM encoding (idle / granted to req0 / granted to req1)
//   - DefaultDw   : default data width of each requester and of the output
//   - DefaultCntW : default width of the optional per-requester grant counters
// Optional feature macro used by the arbiter: MUX2_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultDw   = 8;
    localparam int unsigned DefaultCntW = 16;

endpackage

// File: rtl/mux2_word.sv
// -----------------------------------------------------------------------------
// mux2_word
// W-bit combinational 2:1 word mux.
// Ports:
//   d0_i [W]  word selected when s_i = 0
//   d1_i [W]  word selected when s_i = 1
//   s_i       select
//   y_o  [W]  selected word
// -----------------------------------------------------------------------------
module mux2_word #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic         s_i,
    output logic [W-1:0] y_o
);

    assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
// Round-robin arbiter sharing one 2:1 word mux between two packet requesters.
// A grant is held for a whole packet (until the accepted last beat); the next
// arbitration then favours the other requester. Beats pass through a single
// registered output stage towards one downstream consumer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid_i/_data_i/_last_i  requester N beat (N = 0, 1)
//   reqN_ready_o               requester N beat accepted when valid & ready
//   out_valid_o/_data_o/_last_o   registered output beat
//   out_ready_i                downstream accepts when out_valid & out_ready
//   sel_o                      current mux select / grant owner (registered)
//   grant_cnt0_o, grant_cnt1_o saturating packet-grant counters
//                              (present only with MUX2_ARB_STATS_EN defined)
//
// Optional feature: define MUX2_ARB_STATS_EN to add the grant counters.
// -----------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid_i,
    input  logic [DW-1:0]    req0_data_i,
    input  logic             req0_last_i,
    output logic             req0_ready_o,

    input  logic             req1_valid_i,
    input  logic [DW-1:0]    req1_data_i,
    input  logic             req1_last_i,
    output logic             req1_ready_o,

    output logic             out_valid_o,
    output logic [DW-1:0]    out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,

`ifdef MUX2_ARB_STATS_EN
    output logic [CNT_W-1:0] grant_cnt0_o,
    output logic [CNT_W-1:0] grant_cnt1_o,
`endif
    output logic             sel_o
);

    arb_state_e     state_q, state_d;
    logic           prio_q, prio_d;
    logic           sel_q, sel_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;

    logic [DW:0]    mux_y;
    logic           acc0, acc1, accept;
    logic           grant0, grant1;

    // Data and last travel together through the shared mux.
    mux2_word #(
        .W (DW + 1)
    ) u_mux (
        .d0_i ({req0_last_i, req0_data_i}),
        .d1_i ({req1_last_i, req1_data_i}),
        .s_i  (sel_q),
        .y_o  (mux_y)
    );

    always_comb begin
        req0_ready_o = (state_q == StGnt0) && (!out_valid_q || out_ready_i);
        req1_ready_o = (state_q == StGnt1) && (!out_valid_q || out_ready_i);
        acc0   = req0_valid_i && req0_ready_o;
        acc1   = req1_valid_i && req1_ready_o;
        accept = acc0 || acc1;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        case (state_q)
            StIdle: begin
                // prio_q = 1 favours req1 when both are valid.
                if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
                    state_d = StGnt0;
                    sel_d   = 1'b0;
                end else if (req1_valid_i) begin
                    state_d = StGnt1;
                    sel_d   = 1'b1;
                end
            end
            StGnt0: begin
                if (acc0 && req0_last_i) begin
                    state_d = StIdle;
                    prio_d  = 1'b1;
                end
            end
            StGnt1: begin
                if (acc1 && req1_last_i) begin
                    state_d = StIdle;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        grant0 = (state_q == StIdle) && (state_d == StGnt0);
        grant1 = (state_q == StIdle) && (state_d == StGnt1);
    end

    // Output stage: load on accept, drain when consumed, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y[DW-1:0];
            out_last_d  = mux_y[DW];
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign sel_o       = sel_q;

`ifdef MUX2_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Counters saturate at all-ones instead of wrapping.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (grant0 && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
        if (grant1 && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0_o = grant_cnt0_q;
    assign grant_cnt1_o = grant_cnt1_q;
`else
    logic             unused_grant;
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_grant = grant0 ^ grant1;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_rr_arbiter
// Directed self-checking bench for mux2_rr_arbiter. Each cycle drives one row
// of requester/out_ready stimulus and compares the arbiter outputs against
// hand-derived values. Counter checks are compiled in with MUX2_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

`ifdef MUX2_ARB_STATS_EN
    localparam int unsigned TbCntW = 4;
`else
    localparam int unsigned TbCntW = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic       sel;
`ifdef MUX2_ARB_STATS_EN
    logic [TbCntW-1:0] grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mux2_rr_arbiter #(
        .DW    (8),
        .CNT_W (TbCntW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_data_i  (req0_data),
        .req0_last_i  (req0_last),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_data_i  (req1_data),
        .req1_last_i  (req1_last),
        .req1_ready_o (req1_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready),
`ifdef MUX2_ARB_STATS_EN
        .grant_cnt0_o (grant_cnt0),
        .grant_cnt1_o (grant_cnt1),
`endif
        .sel_o        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic er0, input logic er1,
                              input logic esel, input logic eov, input logic [7:0] eod,
                              input logic eol);
        check_eq({tag, ".req0_ready"}, 32'(req0_ready), 32'(er0));
        check_eq({tag, ".req1_ready"}, 32'(req1_ready), 32'(er1));
        check_eq({tag, ".sel"},        32'(sel),        32'(esel));
        check_eq({tag, ".out_valid"},  32'(out_valid),  32'(eov));
        check_eq({tag, ".out_data"},   32'(out_data),   32'(eod));
        check_eq({tag, ".out_last"},   32'(out_last),   32'(eol));
    endtask

    // One cycle: drive inputs just after the edge, check, then advance past the next edge.
    task automatic cyc(input string tag,
                       input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic ordy,
                       input logic er0, input logic er1, input logic esel,
                       input logic eov, input logic [7:0] eod, input logic eol);
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
        out_ready  = ordy;
        #1;
        check_outs(tag, er0, er1, esel, eov, eod, eol);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted while traffic is being offered.
        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outs("RST", 0, 0, 0, 0, 8'h00, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;

        // req0 alone, 3-beat packet A0..A2.
        cyc("A0", 1, 8'hA0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0);
        cyc("A1", 1, 8'hA0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("A2", 1, 8'hA1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 8'hA0, 0);
        cyc("A3", 1, 8'hA2, 1, 0, 8'h00, 0, 1, 1, 0, 0, 1, 8'hA1, 0);
        cyc("A4", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA2, 1);
        cyc("A5", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'hA2, 1);

        // req1 starts a packet (favoured now); reset lands mid-packet.
        cyc("C0", 0, 8'h00, 0, 1, 8'hC0, 0, 1, 0, 0, 0, 0, 8'hA2, 1);
        cyc("C1", 0, 8'h00, 0, 1, 8'hC0, 0, 1, 0, 1, 1, 0, 8'hA2, 1);
        cyc("C2", 0, 8'h00, 0, 1, 8'hC1, 0, 1, 0, 1, 1, 1, 8'hC0, 0);
        rst_n = 1'b0;
        #1;
        check_outs("RSTMID", 0, 0, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        rst_n      = 1'b1;

        // Both valid after reset: req0 first, then req1, then req0 (single beat).
        cyc("B0", 1, 8'hB0, 0, 1, 8'hD0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
        cyc("B1", 1, 8'hB0, 0, 1, 8'hD0, 0, 1, 1, 0, 0, 0, 8'h00, 0);
        cyc("B2", 1, 8'hB1, 1, 1, 8'hD0, 0, 1, 1, 0, 0, 1, 8'hB0, 0);
        cyc("B3", 1, 8'hE0, 1, 1, 8'hD0, 0, 1, 0, 0, 0, 1, 8'hB1, 1);
        cyc("B4", 1, 8'hE0, 1, 1, 8'hD0, 0, 1, 0, 1, 1, 0, 8'hB1, 1);
        cyc("B5", 1, 8'hE0, 1, 1, 8'hD1, 1, 1, 0, 1, 1, 1, 8'hD0, 0);
        cyc("B6", 1, 8'hE0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'hD1, 1);
        cyc("B7", 1, 8'hE0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'hD1, 1);
        cyc("B8", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hE0, 1);
        cyc("B9", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'hE0, 1);

        // req1 4-beat packet with downstream stalled for four cycles.
        cyc("D0",  0, 8'h00, 0, 1, 8'hF0, 0, 1, 0, 0, 0, 0, 8'hE0, 1);
        cyc("D1",  0, 8'h00, 0, 1, 8'hF0, 0, 1, 0, 1, 1, 0, 8'hE0, 1);
        cyc("D2",  0, 8'h00, 0, 1, 8'hF1, 0, 1, 0, 1, 1, 1, 8'hF0, 0);
        cyc("D3",  0, 8'h00, 0, 1, 8'hF2, 0, 0, 0, 0, 1, 1, 8'hF1, 0);
        cyc("D4",  0, 8'h00, 0, 1, 8'hF2, 0, 0, 0, 0, 1, 1, 8'hF1, 0);
        cyc("D5",  0, 8'h00, 0, 1, 8'hF2, 0, 0, 0, 0, 1, 1, 8'hF1, 0);
        cyc("D6",  0, 8'h00, 0, 1, 8'hF2, 0, 0, 0, 0, 1, 1, 8'hF1, 0);
        cyc("D7",  0, 8'h00, 0, 1, 8'hF2, 0, 1, 0, 1, 1, 1, 8'hF1, 0);
        cyc("D8",  0, 8'h00, 0, 1, 8'hF3, 1, 1, 0, 1, 1, 1, 8'hF2, 0);
        cyc("D9",  0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'hF3, 1);
        cyc("D10", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'hF3, 1);

        // req0 valid gaps mid-packet while req1 waits: grant stays with req0.
        cyc("E0",  1, 8'h60, 0, 1, 8'h70, 1, 1, 0, 0, 1, 0, 8'hF3, 1);
        cyc("E1",  1, 8'h60, 0, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'hF3, 1);
        cyc("E2",  0, 8'h00, 0, 1, 8'h70, 1, 1, 1, 0, 0, 1, 8'h60, 0);
        cyc("E3",  0, 8'h00, 0, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'h60, 0);
        cyc("E4",  0, 8'h00, 0, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'h60, 0);
        cyc("E5",  0, 8'h00, 0, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'h60, 0);
        cyc("E6",  0, 8'h00, 0, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'h60, 0);
        cyc("E7",  1, 8'h61, 1, 1, 8'h70, 1, 1, 1, 0, 0, 0, 8'h60, 0);
        cyc("E8",  0, 8'h00, 0, 1, 8'h70, 1, 1, 0, 0, 0, 1, 8'h61, 1);
        cyc("E9",  0, 8'h00, 0, 1, 8'h70, 1, 1, 0, 1, 1, 0, 8'h61, 1);
        cyc("E10", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h70, 1);
        cyc("E11", 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h70, 1);

`ifdef MUX2_ARB_STATS_EN
        // Grants since the mid-packet reset: req0 = B, E0, G; req1 = D, F, H.
        check_eq("CNT0.pre", 32'(grant_cnt0), 32'd3);
        check_eq("CNT1.pre", 32'(grant_cnt1), 32'd3);
        // Back-to-back single-beat req0 packets: one grant every two cycles.
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        check_eq("CNT0.14", 32'(grant_cnt0), 32'd14);
        repeat (2) @(posedge clk);
        #1;
        check_eq("CNT0.sat", 32'(grant_cnt0), 32'd15);
        repeat (4) @(posedge clk);
        #1;
        check_eq("CNT0.hold", 32'(grant_cnt0), 32'd15);
        check_eq("CNT1.post", 32'(grant_cnt1), 32'd3);
        req0_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
